// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-flight register-write scoreboard for issue control.
// Ports: clk/nreset; issue_* request from decode; flush from branch unit;
//   stall/issue_fire/fwd_sel1/fwd_sel2 back to decode; wb_valid/wb_rd,
//   busy_mask and a saturating stall_count for observation.
module pipe_scoreboard #(
    parameter int REG_AW     = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 issue_valid,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    input  logic [REG_AW-1:0]    issue_rs1,
    input  logic [REG_AW-1:0]    issue_rs2,
    input  logic                 issue_wr,
    input  logic [REG_AW-1:0]    issue_rd,
    input  logic                 issue_is_load,
    input  logic                 flush,
    output logic                 stall,
    output logic                 issue_fire,
    output logic [SW-1:0]        fwd_sel1,
    output logic [SW-1:0]        fwd_sel2,
    output logic                 wb_valid,
    output logic [REG_AW-1:0]    wb_rd,
    output logic [2**REG_AW-1:0] busy_mask,
    output logic [15:0]          stall_count
);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } ent_t;

    typedef struct packed {
        logic          haz;
        logic [SW-1:0] sel;
    } look_t;

    ent_t [DEPTH-1:0] ent;
    look_t            look1;
    look_t            look2;

    // Scan oldest to youngest so the youngest producer overwrites the result.
    function automatic look_t lookup(
        input ent_t [DEPTH-1:0] e,
        input logic              use_rs,
        input logic [REG_AW-1:0] rs
    );
        look_t r;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (e[k].valid && e[k].wr && e[k].rd == rs) begin
                r.haz = e[k].is_load && (k < LOAD_STAGE);
                r.sel = SW'(k + 1);
            end
        end
        if (!use_rs) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        look1      = lookup(ent, use_rs1, issue_rs1);
        look2      = lookup(ent, use_rs2, issue_rs2);
        stall      = issue_valid & ~flush & (look1.haz | look2.haz);
        issue_fire = issue_valid & ~stall & ~flush;
        fwd_sel1   = issue_fire ? look1.sel : '0;
        fwd_sel2   = issue_fire ? look2.sel : '0;
    end

    always_comb begin
        busy_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent[k].valid && ent[k].wr) begin
                busy_mask[ent[k].rd] = 1'b1;
            end
        end
    end

    assign wb_valid = ent[DEPTH-1].valid & ent[DEPTH-1].wr;
    assign wb_rd    = wb_valid ? ent[DEPTH-1].rd : '0;

    // A flush kills only the youngest entry, on its way into stage 1.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ent         <= '0;
            stall_count <= '0;
        end else begin
            if (issue_fire) begin
                ent[0] <= ent_t'{1'b1, issue_wr, issue_rd, issue_is_load};
            end else begin
                ent[0] <= '0;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (k == 1 && flush) begin
                    ent[k] <= '0;
                end else begin
                    ent[k] <= ent[k-1];
                end
            end
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed table, corner sequences and random run
// of pipe_scoreboard against a timestamp-based in-flight-write model.
module tb_pipe_scoreboard;

    localparam int AW = 4;
    localparam int D  = 3;
    localparam int LS = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          nreset;
    logic          issue_valid, use_rs1, use_rs2;
    logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          issue_wr, issue_is_load, flush;
    logic          stall, issue_fire, wb_valid;
    logic [SW-1:0] fwd_sel1, fwd_sel2;
    logic [AW-1:0] wb_rd;
    logic [15:0]   busy_mask;
    logic [15:0]   stall_count;

    pipe_scoreboard #(.REG_AW(AW), .DEPTH(D), .LOAD_STAGE(LS)) dut (
        .clk(clk), .nreset(nreset),
        .issue_valid(issue_valid), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_is_load(issue_is_load), .flush(flush),
        .stall(stall), .issue_fire(issue_fire),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: list of in-flight writes with issue timestamps.
    // An instruction issued at cycle t sits at stage now-t-1.
    typedef struct {
        int          t;
        logic [3:0]  rd;
        logic        ld;
    } fl_t;

    fl_t         inflight[$];
    int          now;
    logic [15:0] m_cnt;
    logic        m_stall, m_fire, m_wbv;
    logic [1:0]  m_s1, m_s2;
    logic [3:0]  m_wbrd;
    logic [15:0] m_busy;

    task automatic model_reset();
        inflight = {};
        now      = 0;
        m_cnt    = 16'd0;
    endtask

    task automatic model_lookup(input logic u, input logic [3:0] rs,
                                output logic haz, output int sel);
        int   best;
        int   age;
        logic bld;
        best = -1;
        bld  = 1'b0;
        haz  = 1'b0;
        sel  = 0;
        foreach (inflight[i]) begin
            if (inflight[i].rd == rs && inflight[i].t > best) begin
                best = inflight[i].t;
                bld  = inflight[i].ld;
            end
        end
        if (u && best >= 0) begin
            age = now - best - 1;
            if (bld && age < LS) haz = 1'b1;
            else sel = age + 1;
        end
    endtask

    task automatic model_eval();
        logic h1, h2;
        int   s1, s2;
        model_lookup(use_rs1, issue_rs1, h1, s1);
        model_lookup(use_rs2, issue_rs2, h2, s2);
        m_stall = issue_valid && !flush && (h1 || h2);
        m_fire  = issue_valid && !m_stall && !flush;
        m_s1    = m_fire ? 2'(s1) : 2'd0;
        m_s2    = m_fire ? 2'(s2) : 2'd0;
        m_busy  = '0;
        m_wbv   = 1'b0;
        m_wbrd  = '0;
        foreach (inflight[i]) begin
            m_busy[inflight[i].rd] = 1'b1;
            if (now - inflight[i].t - 1 == D - 1) begin
                m_wbv  = 1'b1;
                m_wbrd = inflight[i].rd;
            end
        end
    endtask

    task automatic model_commit();
        fl_t keep[$];
        if (m_stall && m_cnt != 16'hFFFF) m_cnt++;
        foreach (inflight[i]) begin
            if (!(flush && inflight[i].t == now - 1))
                keep.push_back(inflight[i]);
        end
        if (m_fire && issue_wr)
            keep.push_back('{t: now, rd: issue_rd, ld: issue_is_load});
        now++;
        inflight = {};
        foreach (keep[i]) begin
            if (now - keep[i].t - 1 < D) inflight.push_back(keep[i]);
        end
    endtask

    task automatic set_in(input int iv, u1, rs1, u2, rs2,
                          input int wr, rd, ld, fl);
        issue_valid   = iv[0];
        use_rs1       = u1[0];
        issue_rs1     = 4'(rs1);
        use_rs2       = u2[0];
        issue_rs2     = 4'(rs2);
        issue_wr      = wr[0];
        issue_rd      = 4'(rd);
        issue_is_load = ld[0];
        flush         = fl[0];
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       iv, u1, u2, wr, ld, fl;
        logic [3:0] rs1, rs2, rd;
        logic       es, ef, ewv;
        logic [1:0] e1, e2;
        logic [3:0] ewr;
        logic [15:0] ec;
    } vec_t;

    function automatic vec_t mk(input int iv, u1, rs1, u2, rs2, wr, rd,
                                input int ld, fl, es, ef, e1, e2,
                                input int ewv, ewr, ec);
        vec_t v;
        v.iv = iv[0];   v.u1 = u1[0];   v.rs1 = 4'(rs1);
        v.u2 = u2[0];   v.rs2 = 4'(rs2); v.wr = wr[0];
        v.rd = 4'(rd);  v.ld = ld[0];   v.fl = fl[0];
        v.es = es[0];   v.ef = ef[0];   v.e1 = 2'(e1);
        v.e2 = 2'(e2);  v.ewv = ewv[0]; v.ewr = 4'(ewr);
        v.ec = 16'(ec);
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //             iv u1 r1 u2 r2 wr rd ld fl  st fi s1 s2 wv wr cnt
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 3, 0));
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 1, 0, 3, 1, 5, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 2, 0, 0, 1, 9, 1, 0, 0, 1, 0, 0, 1, 2, 2));
        tbl.push_back(mk(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));

        // Reset state, with inputs that would otherwise hit.
        nreset = 1'b0;
        idle();
        model_reset();
        @(posedge clk);
        #1;
        set_in(1, 1, 3, 1, 5, 1, 3, 1, 0);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_sel1", 32'(fwd_sel1), 0);
        chk("rst_sel2", 32'(fwd_sel2), 0);
        chk("rst_wbv", 32'(wb_valid), 0);
        chk("rst_wbrd", 32'(wb_rd), 0);
        chk("rst_busy", 32'(busy_mask), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        @(posedge clk);
        #1;
        idle();
        nreset = 1'b1;

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            set_in(v.iv, v.u1, v.rs1, v.u2, v.rs2, v.wr, v.rd, v.ld, v.fl);
            settle();
            chk($sformatf("t%0d_stall", i), 32'(stall), 32'(v.es));
            chk($sformatf("t%0d_fire", i), 32'(issue_fire), 32'(v.ef));
            chk($sformatf("t%0d_wbv", i), 32'(wb_valid), 32'(v.ewv));
            chk($sformatf("t%0d_cnt", i), 32'(stall_count), 32'(v.ec));
            if (v.iv) begin
                chk($sformatf("t%0d_sel1", i), 32'(fwd_sel1), 32'(v.e1));
                chk($sformatf("t%0d_sel2", i), 32'(fwd_sel2), 32'(v.e2));
            end
            if (v.ewv)
                chk($sformatf("t%0d_wbrd", i), 32'(wb_rd), 32'(v.ewr));
            advance();
        end

        // Flush together with a load-use hazard.
        set_in(1, 0, 0, 0, 0, 1, 5, 1, 0);
        settle();
        chk("fh_ld_fire", 32'(issue_fire), 1);
        advance();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 1);
        settle();
        chk("fh_stall", 32'(stall), 0);
        chk("fh_fire", 32'(issue_fire), 0);
        chk("fh_busy5", 32'(busy_mask), 32'h20);
        advance();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 0);
        settle();
        chk("fh_cnt", 32'(stall_count), 2);
        chk("fh_stall2", 32'(stall), 0);
        chk("fh_fire2", 32'(issue_fire), 1);
        chk("fh_sel1", 32'(fwd_sel1), 0);
        chk("fh_busy", 32'(busy_mask), 0);
        advance();
        idle();
        settle();
        advance();
        settle();
        advance();

        // Asynchronous reset with three writes in flight.
        for (int r = 1; r <= 3; r++) begin
            set_in(1, 0, 0, 0, 0, 1, r, 0, 0);
            settle();
            advance();
        end
        idle();
        settle();
        chk("pre_busy", 32'(busy_mask), 32'h000E);
        chk("pre_wbv", 32'(wb_valid), 1);
        chk("pre_wbrd", 32'(wb_rd), 1);
        nreset = 1'b0;
        #1;
        chk("mr_busy", 32'(busy_mask), 0);
        chk("mr_wbv", 32'(wb_valid), 0);
        chk("mr_cnt", 32'(stall_count), 0);
        chk("mr_stall", 32'(stall), 0);
        model_reset();
        @(posedge clk);
        #1;
        nreset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("mr_after%0d_wbv", c), 32'(wb_valid), 0);
            advance();
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 9) < 8) ? 1 : 0,
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 3),
                   ($urandom_range(0, 9) < 3) ? 1 : 0,
                   ($urandom_range(0, 9) < 1) ? 1 : 0);
            settle();
            chk($sformatf("r%0d_stall", c), 32'(stall), 32'(m_stall));
            chk($sformatf("r%0d_fire", c), 32'(issue_fire), 32'(m_fire));
            chk($sformatf("r%0d_wbv", c), 32'(wb_valid), 32'(m_wbv));
            chk($sformatf("r%0d_busy", c), 32'(busy_mask), 32'(m_busy));
            chk($sformatf("r%0d_cnt", c), 32'(stall_count), 32'(m_cnt));
            if (issue_valid) begin
                chk($sformatf("r%0d_sel1", c), 32'(fwd_sel1), 32'(m_s1));
                chk($sformatf("r%0d_sel2", c), 32'(fwd_sel2), 32'(m_s2));
            end
            if (m_wbv)
                chk($sformatf("r%0d_wbrd", c), 32'(wb_rd), 32'(m_wbrd));
            advance();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised issue-control block for the pipelined CPU. It replaces the fixed pairwise hazard comparators and the global three-cycle freeze with a per-stage in-flight-write scoreboard. Sitting between decode and register read, it tracks every in-flight register write through DEPTH post-issue stages. For each source it produces forwarding selects, stalls only on true load-use hazards, and kills the youngest in-flight instruction on a taken branch.

## Interface
- REG_AW, 4, register address width (2**REG_AW architectural registers)
- DEPTH, 3, post-issue stages holding in-flight writes (stage 0 = execute … stage DEPTH-1 = writeback); DEPTH >= 1
- LOAD_STAGE, 2, first stage index at which load data is forwardable; 0 <= LOAD_STAGE <= DEPTH-1
- SW, $clog2(DEPTH+1), width of forwarding selects (derived)

- clk  in  1  clock; all state updates on rising edge
- nreset  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode holds an instruction requesting issue
- use_rs1, use_rs2  in  1  source operand actually read
- issue_rs1, issue_rs2  in  REG_AW  source register numbers
- issue_wr  in  1  instruction writes a register
- issue_rd  in  REG_AW  destination register
- issue_is_load  in  1  destination data is produced by memory
- flush  in  1  taken branch resolved this cycle
- stall  out  1  hold decode and PC this cycle
- issue_fire  out  1  issue_valid & ~stall & ~flush
- fwd_sel1, fwd_sel2  out  SW  0 = register file, k = forward from stage k-1
- wb_valid  out  1  stage DEPTH-1 holds a valid write this cycle
- wb_rd  out  REG_AW  its destination
- busy_mask  out  2**REG_AW  bit r set when any valid in-flight entry writes r
- stall_count  out  16  saturating count of load-use stall cycles

## Operation
- State: DEPTH entries {valid, wr, rd, is_load}, a shift register indexed by stage.
- Every cycle each entry k moves to k+1, and entry DEPTH-1 retires. Stage 0 loads {1, issue_wr, issue_rd, issue_is_load} when issue_fire. Otherwise stage 0 loads a bubble (valid=0).
- Per used source rsN: match_k = valid_k & wr_k & (rd_k == rsN). Take the smallest k with match (youngest producer wins).
  - No match, or source unused: fwd_selN = 0.
  - Match at k with is_load_k and k < LOAD_STAGE: raise hazard.
  - Otherwise fwd_selN = k+1.
- stall = issue_valid & ~flush & (hazard on rs1 | hazard on rs2). Combinational; no register dependency on stall.
- flush has priority over stall. issue_fire = 0. Entry in stage 0 is replaced by a bubble when shifting into stage 1. Older stages are untouched.
- fwd_sel outputs are valid whenever issue_valid. They are 0 when stall or flush.
- busy_mask and wb_valid/wb_rd are combinational from current state.
- stall_count increments when stall = 1. It holds at 16'hFFFF.

## Timing
- Reset (nreset low, async): all entries invalid, stall_count = 0. Hence stall = 0, wb_valid = 0, wb_rd = 0, busy_mask = 0, and fwd_sel = 0 regardless of inputs.
- Reset mid-operation discards all in-flight entries immediately. No retirement is reported.
- An instruction firing in cycle N occupies stage k in cycle N+1+k. wb_valid for it is asserted in cycle N+DEPTH.
- ALU producer at N, consumer at N+j (1 <= j <= DEPTH): no stall, fwd_sel = j. At N+DEPTH+1 the consumer gets fwd_sel = 0.
- Load producer at N, consumer at N+1: stalls for LOAD_STAGE cycles and fires at N+1+LOAD_STAGE with fwd_sel = LOAD_STAGE+1.
- Retiring stage (DEPTH-1) is still forwarded; the register file is not write-through.
- No register-address special case: register 0 is tracked like any other.

## Test plan
- Reset: pulse nreset low mid-run with 3 entries valid → same cycle busy_mask = 0, wb_valid = 0, stall_count = 0; no wb_valid afterwards.
- ALU chain (defaults): write r3 fires at cycle 0; readers of r3 at cycles 1, 2, 3, 4 → stall = 0, fwd_sel1 = 1, 2, 3, 0; wb_valid with wb_rd = 3 in cycle 3.
- Load-use: load r5 at cycle 0, reader of r5 via rs2 at cycle 1 → stall = 1 in cycles 1–2, issue_fire at cycle 3 with fwd_sel2 = 3, stall_count = 2.
- Youngest wins: writes to r2 at cycles 0 and 1, reader at cycle 2 → fwd_sel1 = 1. Also unused source: use_rs1 = 0 with a matching load in stage 0 → no stall, fwd_sel1 = 0.
- Flush: write r7 at cycle 0; at cycle 1 assert flush with a reader of r7 → issue_fire = 0, stall = 0. Also, with the r7 entry in stage 1 at cycle 1, flush at cycle 1 leaves that entry intact (busy_mask[7] stays 1 until wb in cycle 2).
- Simultaneous flush and load-use hazard → stall = 0, stall_count unchanged, stage 0 bubble next cycle.
